// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the run controller of the single-cycle RISC-V core.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    localparam logic [31:0] HALT_JAL_SELF = 32'h0000_006F;
    localparam logic [31:0] EBREAK        = 32'h0010_0073;

endpackage

// File: rtl/run_cycle_counter.sv
// 32-bit RUN cycle counter; holds at all-ones instead of wrapping.
module run_cycle_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Load/run/done sequencer: streams a program into imem with the core held in
// reset, releases the core, and stops it on a halt instruction or cycle limit.
//
// state | meaning
// IDLE  | waiting for go; core held in reset
// LOAD  | accepting program words into imem; core held in reset
// RUN   | core released; counting cycles, watching for halt / limit
// DONE  | run finished; results held until the next go
module cpu_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned CYCLE_LIMIT = 300,
    parameter logic [31:0] HALT_INSTR  = HALT_JAL_SELF
) (
    input  logic               clk,
    input  logic               start,
    input  logic               go,
    input  logic               abort,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [31:0]        ld_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_start,
    input  logic [31:0]        cpu_pc,
    input  logic [31:0]        cpu_instr,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [31:0]        cycle_count,
    output logic [31:0]        halt_pc
);

    localparam logic [IMEM_AW:0]   MAX_LEN  = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0]   LEN_ONE  = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] PTR_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [31:0]        LIMIT_M1 = 32'(CYCLE_LIMIT - 1);

    run_state_e         state_q, state_d;
    logic [IMEM_AW:0]   len_q;
    logic [IMEM_AW:0]   len_in;
    logic [IMEM_AW-1:0] wr_ptr_q;
    logic               ld_ready_q;
    logic               cpu_start_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic [31:0]        halt_pc_q;

    logic go_ok;
    logic accept;
    logic last_word;
    logic capture;
    logic timeout_set;
    logic cnt_en;

    assign len_in    = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign last_word = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d     = state_q;
        go_ok       = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_set = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    go_ok   = 1'b1;
                    state_d = (len_in == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ld_valid && ld_ready_q) begin
                    accept = 1'b1;
                    if (last_word) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // a halt on the limit cycle is reported as a halt, not a timeout
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cpu_instr == HALT_INSTR) begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                    end else if (cycle_count >= LIMIT_M1) begin
                        state_d     = ST_DONE;
                        capture     = 1'b1;
                        timeout_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            ld_ready_q  <= 1'b0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            halt_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            ld_ready_q  <= (state_d == ST_LOAD);
            cpu_start_q <= (state_d == ST_RUN);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            if (go_ok) begin
                len_q     <= len_in;
                wr_ptr_q  <= '0;
                timeout_q <= 1'b0;
                halt_pc_q <= '0;
            end else begin
                if (accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (capture) begin
                    halt_pc_q <= cpu_pc;
                    timeout_q <= timeout_set;
                end
            end
        end
    end

    run_cycle_counter u_cycle_counter (
        .clk   (clk),
        .rst_n (start),
        .clr   (go_ok),
        .en    (cnt_en),
        .count (cycle_count)
    );

    assign ld_ready   = ld_ready_q;
    assign imem_we    = accept;
    assign imem_addr  = (state_q == ST_LOAD) ? wr_ptr_q : '0;
    assign imem_wdata = accept ? ld_data : '0;
    assign cpu_start  = cpu_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign halt_pc    = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny core model fetching from a bench imem.
module tb_cpu_run_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          start;
    logic          go;
    logic          abort;
    logic [AW:0]   prog_len;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_start;
    logic [31:0]   cpu_pc;
    logic [31:0]   cpu_instr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   cycle_count;
    logic [31:0]   halt_pc;

    logic [31:0] mem [256];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    int n_chk  = 0;
    int n_pass = 0;

    cpu_run_ctrl #(.IMEM_AW(AW), .CYCLE_LIMIT(300), .HALT_INSTR(32'h0000_006F)) dut (
        .clk         (clk),
        .start       (start),
        .go          (go),
        .abort       (abort),
        .prog_len    (prog_len),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_start   (cpu_start),
        .cpu_pc      (cpu_pc),
        .cpu_instr   (cpu_instr),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc)
    );

    always #5 clk = ~clk;

    // core model: PC held at 0 while cpu_start is low, +4 per cycle otherwise
    always @(posedge clk or negedge start) begin
        if (!start)          cpu_pc <= 32'd0;
        else if (!cpu_start) cpu_pc <= 32'd0;
        else                 cpu_pc <= cpu_pc + 32'd4;
    end
    assign cpu_instr = mem[cpu_pc[AW+1:2]];

    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            wlog_a.push_back(32'(imem_addr));
            wlog_d.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic pulse_go(input logic [AW:0] len);
        go = 1'b1;
        prog_len = len;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && done !== 1'b1; i++) @(negedge clk);
        check("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        start = 1'b0; go = 1'b0; abort = 1'b0; prog_len = '0;
        ld_valid = 1'b0; ld_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cpu_start", 32'(cpu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_count", cycle_count, 32'd0);
        check("rst_halt_pc", halt_pc, 32'd0);
        start = 1'b1;
        @(negedge clk);

        // async reset mid-RUN
        pulse_go('0);
        check("t1_run_busy", 32'(busy), 32'd1);
        check("t1_run_cpu_start", 32'(cpu_start), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_count3", cycle_count, 32'd3);
        start = 1'b0;
        #1;
        check("t1_async_cpu_start", 32'(cpu_start), 32'd0);
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_count", cycle_count, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_cpu_start", 32'(cpu_start), 32'd0);

        // load 4 words with a stall; word 3 is the halt
        wlog_a.delete(); wlog_d.delete();
        pulse_go(9'd4);
        check("t2_ld_ready", 32'(ld_ready), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        ld_valid = 1'b1; ld_data = 32'h0050_0093;
        #1;
        check("t2_we_w0", 32'(imem_we), 32'd1);
        check("t2_addr_w0", 32'(imem_addr), 32'd0);
        @(negedge clk);
        send_word(32'h00a0_0113);
        #1;
        check("t2_we_stall", 32'(imem_we), 32'd0);
        @(negedge clk);
        send_word(32'h0020_81b3);
        ld_valid = 1'b1; ld_data = 32'h0000_006F;
        #1;
        check("t2_cpu_start_pre", 32'(cpu_start), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        check("t2_cpu_start_post", 32'(cpu_start), 32'd1);
        check("t2_ld_ready_post", 32'(ld_ready), 32'd0);
        check("t2_nwrites", 32'(wlog_a.size()), 32'd4);
        if (wlog_a.size() == 4) begin
            check("t2_a0", wlog_a[0], 32'd0);
            check("t2_a1", wlog_a[1], 32'd1);
            check("t2_a2", wlog_a[2], 32'd2);
            check("t2_a3", wlog_a[3], 32'd3);
            check("t2_d0", wlog_d[0], 32'h0050_0093);
            check("t2_d1", wlog_d[1], 32'h00a0_0113);
            check("t2_d2", wlog_d[2], 32'h0020_81b3);
            check("t2_d3", wlog_d[3], 32'h0000_006F);
        end

        // halt at PC 0xC
        wait_done(50);
        check("t3_timeout", 32'(timeout), 32'd0);
        check("t3_count", cycle_count, 32'd4);
        check("t3_halt_pc", halt_pc, 32'h0000_000C);
        check("t3_cpu_start", 32'(cpu_start), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t3_done_held", 32'(done), 32'd1);
        check("t3_count_held", cycle_count, 32'd4);

        // prog_len=0 runs the existing image straight away
        wlog_a.delete(); wlog_d.delete();
        pulse_go('0);
        check("t5a_cpu_start", 32'(cpu_start), 32'd1);
        check("t5a_done_clr", 32'(done), 32'd0);
        check("t5a_count_clr", cycle_count, 32'd0);
        check("t5a_halt_pc_clr", halt_pc, 32'd0);
        wait_done(50);
        check("t5a_count", cycle_count, 32'd4);
        check("t5a_nwrites", 32'(wlog_a.size()), 32'd0);

        // timeout: no halt anywhere
        pulse_go(9'd4);
        for (int i = 0; i < 4; i++) send_word(32'h0000_0013);
        wait_done(400);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_count", cycle_count, 32'd300);
        check("t4_halt_pc", halt_pc, 32'h0000_04AC);

        // prog_len beyond depth is clamped to 256 writes
        wlog_a.delete(); wlog_d.delete();
        pulse_go(9'd261);
        for (int i = 0; i < 261; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h0000_0013;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        check("t5b_nwrites", 32'(wlog_a.size()), 32'd256);
        if (wlog_a.size() > 0) check("t5b_last_addr", wlog_a[wlog_a.size()-1], 32'd255);
        check("t5b_cpu_start", 32'(cpu_start), 32'd1);
        check("t5b_count", cycle_count, 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_abort_busy", 32'(busy), 32'd0);
        check("t5b_abort_cpu_start", 32'(cpu_start), 32'd0);

        // abort with the last-word accept
        wlog_a.delete(); wlog_d.delete();
        pulse_go(9'd2);
        send_word(32'h1111_1111);
        ld_valid = 1'b1; ld_data = 32'h2222_2222; abort = 1'b1;
        #1;
        check("t6_we_abort", 32'(imem_we), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0; abort = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_ld_ready", 32'(ld_ready), 32'd0);
        check("t6_cpu_start", 32'(cpu_start), 32'd0);
        check("t6_nwrites", 32'(wlog_a.size()), 32'd1);
        @(negedge clk);
        check("t6_still_idle", 32'(busy), 32'd0);
        pulse_go('0);
        check("t6_restart_busy", 32'(busy), 32'd1);
        check("t6_restart_count", cycle_count, 32'd0);
        @(negedge clk);
        check("t6_restart_count1", cycle_count, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_final_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
